// File: rtl/ne_fp_pkg.sv
`default_nettype none
// ============================================================================
// Module : ne_fp_pkg
// Brief  : Shared constants and stage-split helpers for the NE FP datapath.
// Rev    : 1.0  initial release
// ============================================================================
package ne_fp_pkg;

    localparam int NE_FP_MAN_W     = 33;
    localparam int NE_FP_SF_W      = 6;
    localparam int NE_FP_FINE_SF_W = 3;

    // Width of the shift-amount slice handled by the fine (1-step) stage.
    function automatic int ne_fp_fine_w(input int sf_w);
        return (sf_w < NE_FP_FINE_SF_W) ? sf_w : NE_FP_FINE_SF_W;
    endfunction

    // Width of the coarse slice; kept at 1 when no coarse bits exist.
    function automatic int ne_fp_coarse_w(input int sf_w);
        return (sf_w > NE_FP_FINE_SF_W) ? (sf_w - NE_FP_FINE_SF_W) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ne_fp_sfr_blk.sv
`default_nettype none
// ============================================================================
// Module : ne_fp_sfr_blk
// Brief  : Combinational right shift by i_amt*STEP with fill and sticky.
//          Sticky output exists only when NE_FP_SFR_STICKY_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
module ne_fp_sfr_blk
    import ne_fp_pkg::*;
#(
    parameter int BW_DATA = NE_FP_MAN_W,
    parameter int BW_AMT  = NE_FP_FINE_SF_W,
    parameter int STEP    = 1
) (
    input  logic [BW_DATA-1:0] i_a,
    input  logic [BW_AMT-1:0]  i_amt,
    input  logic               i_fill,
    output logic [BW_DATA-1:0] o_z
`ifdef NE_FP_SFR_STICKY_EN
    ,
    output logic               o_sticky
`endif
);

    localparam logic [BW_DATA-1:0] C_ONES = '1;

    logic [31:0]        w_sh;
    logic [BW_DATA-1:0] w_keep;

    assign w_sh   = 32'(i_amt) * 32'(STEP);
    // Ones mark bit positions still holding source data after the shift.
    assign w_keep = C_ONES >> w_sh;
    assign o_z    = (i_a >> w_sh) | ({BW_DATA{i_fill}} & ~w_keep);

`ifdef NE_FP_SFR_STICKY_EN
    logic [BW_DATA-1:0] w_lost;

    assign w_lost   = i_a & ~(C_ONES << w_sh);
    assign o_sticky = |w_lost;
`endif

endmodule
`default_nettype wire

// File: rtl/ne_fp_sfr_align_pipe.sv
`default_nettype none
// ============================================================================
// Module : ne_fp_sfr_align_pipe
// Brief  : Two-stage elastic mantissa alignment right shifter (fine 0..7,
//          then coarse x8). Sticky logic built when NE_FP_SFR_STICKY_EN.
// Rev    : 1.0  initial release
// ============================================================================
module ne_fp_sfr_align_pipe
    import ne_fp_pkg::*;
#(
    parameter int BW_DATA = NE_FP_MAN_W,
    parameter int BW_SF   = NE_FP_SF_W,
    parameter int SIGNED  = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_vld,
    output logic               in_rdy,
    input  logic [BW_DATA-1:0] in_a,
    input  logic [BW_SF-1:0]   in_s,
    output logic               out_vld,
    input  logic               out_rdy,
    output logic [BW_DATA-1:0] out_z,
    output logic               out_sticky
);

    localparam int C_FINE_W = ne_fp_fine_w(BW_SF);
    localparam int C_CO_W   = ne_fp_coarse_w(BW_SF);
    localparam int C_CO_STP = 1 << NE_FP_FINE_SF_W;

    logic               r_s1_vld;
    logic [BW_DATA-1:0] r_s1_z;
    logic               r_s1_fill;
    logic [C_CO_W-1:0]  r_s1_hi;
    logic               r_out_vld;
    logic [BW_DATA-1:0] r_out_z;

    logic               w_s1_en;
    logic               w_s2_en;
    logic               w_fill;
    logic [C_CO_W-1:0]  w_hi;
    logic [BW_DATA-1:0] w_s1_z;
    logic [BW_DATA-1:0] w_s2_z;

    assign w_s2_en = !r_out_vld || out_rdy;
    assign w_s1_en = !r_s1_vld || w_s2_en;
    assign in_rdy  = w_s1_en;
    assign out_vld = r_out_vld;
    assign out_z   = r_out_z;
    assign w_fill  = (SIGNED != 0) ? in_a[BW_DATA-1] : 1'b0;

    generate
        if (BW_SF > NE_FP_FINE_SF_W) begin : g_hi
            assign w_hi = in_s[BW_SF-1:NE_FP_FINE_SF_W];
        end else begin : g_no_hi
            assign w_hi = '0;
        end
    endgenerate

`ifdef NE_FP_SFR_STICKY_EN
    logic w_s1_st;
    logic w_s2_st;
    logic r_s1_sticky;
    logic r_out_sticky;
`endif

    ne_fp_sfr_blk #(
        .BW_DATA (BW_DATA),
        .BW_AMT  (C_FINE_W),
        .STEP    (1)
    ) u_fine (
        .i_a      (in_a),
        .i_amt    (in_s[C_FINE_W-1:0]),
        .i_fill   (w_fill),
        .o_z      (w_s1_z)
`ifdef NE_FP_SFR_STICKY_EN
        ,
        .o_sticky (w_s1_st)
`endif
    );

    generate
        if (BW_SF > NE_FP_FINE_SF_W) begin : g_coarse
            ne_fp_sfr_blk #(
                .BW_DATA (BW_DATA),
                .BW_AMT  (C_CO_W),
                .STEP    (C_CO_STP)
            ) u_coarse (
                .i_a      (r_s1_z),
                .i_amt    (r_s1_hi),
                .i_fill   (r_s1_fill),
                .o_z      (w_s2_z)
`ifdef NE_FP_SFR_STICKY_EN
                ,
                .o_sticky (w_s2_st)
`endif
            );
        end else begin : g_pass
            // No coarse bits: stage 2 is a plain register slice.
            assign w_s2_z = r_s1_z;
`ifdef NE_FP_SFR_STICKY_EN
            assign w_s2_st = 1'b0;
`endif
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_vld  <= 1'b0;
            r_s1_z    <= '0;
            r_s1_fill <= 1'b0;
            r_s1_hi   <= '0;
            r_out_vld <= 1'b0;
            r_out_z   <= '0;
        end else begin
            if (w_s1_en) begin
                r_s1_vld <= in_vld;
            end
            if (w_s1_en && in_vld) begin
                r_s1_z    <= w_s1_z;
                r_s1_fill <= w_fill;
                r_s1_hi   <= w_hi;
            end
            if (w_s2_en) begin
                r_out_vld <= r_s1_vld;
            end
            if (w_s2_en && r_s1_vld) begin
                r_out_z <= w_s2_z;
            end
        end
    end

`ifdef NE_FP_SFR_STICKY_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_sticky  <= 1'b0;
            r_out_sticky <= 1'b0;
        end else begin
            if (w_s1_en && in_vld) begin
                r_s1_sticky <= w_s1_st;
            end
            if (w_s2_en && r_s1_vld) begin
                r_out_sticky <= r_s1_sticky | w_s2_st;
            end
        end
    end

    assign out_sticky = r_out_sticky;
`else
    assign out_sticky = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ne_fp_sfr_align_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_ne_fp_sfr_align_pipe
// Brief  : Self-checking bench; SIGNED=0 and SIGNED=1 instances in lockstep.
//          Sticky expectations follow NE_FP_SFR_STICKY_EN.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ne_fp_sfr_align_pipe;
    import ne_fp_pkg::*;

    localparam int W  = NE_FP_MAN_W;
    localparam int SW = NE_FP_SF_W;
    localparam int NV = 10;
`ifdef NE_FP_SFR_STICKY_EN
    localparam bit C_STK = 1'b1;
`else
    localparam bit C_STK = 1'b0;
`endif

    typedef struct {
        logic [W-1:0]  a;
        logic [SW-1:0] s;
        logic [W-1:0]  z0;
        logic          st0;
        logic [W-1:0]  z1;
        logic          st1;
    } vec_t;

    typedef struct {
        logic [W-1:0] z0;
        logic         st0;
        logic [W-1:0] z1;
        logic         st1;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_vld = 1'b0;
    logic          out_rdy = 1'b0;
    logic [W-1:0]  in_a = '0;
    logic [SW-1:0] in_s = '0;
    logic          rdy0, rdy1, vld0, vld1, st0, st1;
    logic [W-1:0]  z0, z1;

    int     n_checks = 0;
    int     n_errors = 0;
    int     n_pops = 0;
    int     first_pop = 0;
    int     last_pop = 0;
    int     cyc = 0;
    exp_t   sb[$];
    exp_t   next_exp;
    logic   use_next = 1'b0;
    logic   stall_prev = 1'b0;
    logic [W-1:0] z0_p, z1_p;
    logic   st0_p, st1_p;
    vec_t   tbl[NV];

    always #5 clk = ~clk;

    ne_fp_sfr_align_pipe #(.BW_DATA(W), .BW_SF(SW), .SIGNED(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(rdy0),
        .in_a(in_a), .in_s(in_s), .out_vld(vld0), .out_rdy(out_rdy),
        .out_z(z0), .out_sticky(st0)
    );

    ne_fp_sfr_align_pipe #(.BW_DATA(W), .BW_SF(SW), .SIGNED(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(rdy1),
        .in_a(in_a), .in_s(in_s), .out_vld(vld1), .out_rdy(out_rdy),
        .out_z(z1), .out_sticky(st1)
    );

    function automatic logic stk(input logic v);
        return v & C_STK;
    endfunction

    // Arithmetic reference: divide by 2^s, remainder gives sticky, add fill.
    function automatic void ref_shift(input logic [W-1:0] a, input int s, input bit sg,
                                      output logic [W-1:0] z, output logic st);
        longint unsigned av, pw, hi;
        logic fill;
        av   = 64'(a);
        fill = sg && a[W-1];
        if (s >= W) begin
            z  = fill ? '1 : '0;
            st = (av != 0);
        end else begin
            pw = 64'd1 << s;
            hi = fill ? ((64'd1 << W) - (64'd1 << (W - s))) : 64'd0;
            z  = W'((av / pw) + hi);
            st = (av % pw) != 0;
        end
        st = stk(st);
    endfunction

    function automatic exp_t model(input logic [W-1:0] a, input int s);
        exp_t e;
        ref_shift(a, s, 1'b0, e.z0, e.st0);
        ref_shift(a, s, 1'b1, e.z1, e.st1);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Evaluates handshakes in the low phase, then advances one clock.
    task automatic tick();
        exp_t e;
        #1;
        if (!rst_n) begin
            sb.delete();
        end else begin
            chk("lockstep", {62'd0, rdy0, vld0}, {62'd0, rdy1, vld1});
            if (stall_prev) begin
                chk("stall_vld", {63'd0, vld0}, 64'd1);
                chk("stall_z0", 64'(z0), 64'(z0_p));
                chk("stall_z1", 64'(z1), 64'(z1_p));
                chk("stall_st", {62'd0, st0, st1}, {62'd0, st0_p, st1_p});
            end
            if (vld0 && out_rdy) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_out: got %h expected none", z0);
                end else begin
                    e = sb.pop_front();
                    chk("out_z0", 64'(z0), 64'(e.z0));
                    chk("out_st0", {63'd0, st0}, {63'd0, e.st0});
                    chk("out_z1", 64'(z1), 64'(e.z1));
                    chk("out_st1", {63'd0, st1}, {63'd0, e.st1});
                end
                if (n_pops == 0) first_pop = cyc;
                last_pop = cyc;
                n_pops++;
            end
            if (in_vld && rdy0) sb.push_back(use_next ? next_exp : model(in_a, int'(in_s)));
        end
        stall_prev = rst_n && vld0 && !out_rdy;
        z0_p  = z0;
        z1_p  = z1;
        st0_p = st0;
        st1_p = st1;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic rand_beat();
        in_vld = 1'b1;
        in_a   = {1'($urandom_range(0, 1)), $urandom()};
        in_s   = 6'($urandom_range(0, 63));
    endtask

    initial begin
        logic acc;
        tbl[0] = '{33'h1_0000_0000, 6'd4,  33'h0_1000_0000, stk(1'b0), 33'h1_F000_0000, stk(1'b0)};
        tbl[1] = '{33'h0_0000_00FF, 6'd4,  33'h0_0000_000F, stk(1'b1), 33'h0_0000_000F, stk(1'b1)};
        tbl[2] = '{33'h1_0000_0000, 6'd8,  33'h0_0100_0000, stk(1'b0), 33'h1_FF00_0000, stk(1'b0)};
        tbl[3] = '{33'h1_0000_0000, 6'd40, 33'h0_0000_0000, stk(1'b1), 33'h1_FFFF_FFFF, stk(1'b1)};
        tbl[4] = '{33'h1_2345_6789, 6'd0,  33'h1_2345_6789, stk(1'b0), 33'h1_2345_6789, stk(1'b0)};
        tbl[5] = '{33'h0_8000_0001, 6'd32, 33'h0_0000_0000, stk(1'b1), 33'h0_0000_0000, stk(1'b1)};
        tbl[6] = '{33'h1_0000_0000, 6'd33, 33'h0_0000_0000, stk(1'b1), 33'h1_FFFF_FFFF, stk(1'b1)};
        tbl[7] = '{33'h0_0000_0000, 6'd63, 33'h0_0000_0000, stk(1'b0), 33'h0_0000_0000, stk(1'b0)};
        tbl[8] = '{33'h0_0000_0080, 6'd7,  33'h0_0000_0001, stk(1'b0), 33'h0_0000_0001, stk(1'b0)};
        tbl[9] = '{33'h1_0000_0100, 6'd9,  33'h0_0080_0000, stk(1'b1), 33'h1_FF80_0000, stk(1'b1)};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_vld", {62'd0, vld0, vld1}, 64'd0);
        chk("rst_z", 64'(z0 | z1), 64'd0);
        chk("rst_st", {62'd0, st0, st1}, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_rdy", {63'd0, rdy0}, 64'd1);

        // Latency from accept to out_vld
        use_next = 1'b1;
        out_rdy  = 1'b1;
        in_vld   = 1'b1;
        in_a     = tbl[0].a;
        in_s     = tbl[0].s;
        next_exp = '{tbl[0].z0, tbl[0].st0, tbl[0].z1, tbl[0].st1};
        tick();
        in_vld = 1'b0;
        #1 chk("lat1_vld", {63'd0, vld0}, 64'd0);
        tick();
        #1 chk("lat2_vld", {63'd0, vld0}, 64'd1);
        tick();

        // Table vectors streamed back to back
        n_pops = 0;
        for (int i = 0; i < NV; i++) begin
            in_vld   = 1'b1;
            in_a     = tbl[i].a;
            in_s     = tbl[i].s;
            next_exp = '{tbl[i].z0, tbl[i].st0, tbl[i].z1, tbl[i].st1};
            #1 chk("tbl_rdy", {63'd0, rdy0}, 64'd1);
            tick();
        end
        in_vld   = 1'b0;
        use_next = 1'b0;
        repeat (4) tick();
        chk("tbl_pops", 64'(n_pops), 64'(NV));
        chk("tbl_gap", 64'(last_pop - first_pop), 64'(NV - 1));

        // Backpressure: capacity two, then drain in order
        n_pops  = 0;
        out_rdy = 1'b0;
        for (int b = 0; b < 3; b++) begin
            rand_beat();
            #1 chk(b < 2 ? "bp_rdy_hi" : "bp_rdy_lo", {63'd0, rdy0}, (b < 2) ? 64'd1 : 64'd0);
            tick();
        end
        repeat (2) tick();
        #1 chk("bp_rdy_hold", {63'd0, rdy0}, 64'd0);
        out_rdy = 1'b1;
        tick();
        in_vld = 1'b0;
        repeat (4) tick();
        chk("bp_pops", 64'(n_pops), 64'd3);
        chk("bp_gap", 64'(last_pop - first_pop), 64'd2);

        // Streaming 8 random beats
        n_pops = 0;
        for (int i = 0; i < 8; i++) begin
            rand_beat();
            #1 chk("strm_rdy", {63'd0, rdy0}, 64'd1);
            tick();
        end
        in_vld = 1'b0;
        repeat (4) tick();
        chk("strm_pops", 64'(n_pops), 64'd8);
        chk("strm_gap", 64'(last_pop - first_pop), 64'd7);

        // Reset with two beats in flight
        out_rdy = 1'b0;
        repeat (2) begin
            rand_beat();
            tick();
        end
        in_vld = 1'b0;
        rst_n  = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("mrst_vld", {62'd0, vld0, vld1}, 64'd0);
        chk("mrst_z", 64'(z0 | z1), 64'd0);
        chk("mrst_st", {62'd0, st0, st1}, 64'd0);
        n_pops  = 0;
        out_rdy = 1'b1;
        repeat (6) tick();
        chk("mrst_nopop", 64'(n_pops), 64'd0);

        // Random traffic with random backpressure
        acc = 1'b1;
        for (int i = 0; i < 400; i++) begin
            out_rdy = ($urandom_range(0, 9) < 7);
            if (!in_vld || acc) begin
                if ($urandom_range(0, 9) < 7) rand_beat();
                else in_vld = 1'b0;
            end
            #1 acc = in_vld && rdy0;
            tick();
        end
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
        chk("drain_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
